// File: rtl/pipeline_check_pkg.sv
// Shared types and limits for the pipeline_check elastic pipeline.
package pipeline_check_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int MAX_DEPTH      = 8;

    typedef logic [DATA_W_DEFAULT-1:0] word_t;

    typedef struct packed {
        logic  valid;
        word_t data;
    } slot_t;

    // Legal stage counts are 1..MAX_DEPTH.
    function automatic logic depth_ok(input int depth);
        return (depth >= 1) && (depth <= MAX_DEPTH);
    endfunction

endpackage

// File: rtl/pipeline_check_stage.sv
// One full-throughput skid buffer: a main register plus a skid register,
// with a registered ready so out_ready never reaches in_ready combinationally.
module pipeline_check_stage
    import pipeline_check_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out
);

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              ready_q, ready_d;
    logic              accept_s;
    logic              drain_s;

    // Next-state for main/skid occupancy and the registered ready.
    always_comb begin
        accept_s     = in_valid && ready_q;
        drain_s      = main_valid_q && out_ready;
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;

        if (drain_s) begin
            // ready_q is low whenever skid holds a word, so no accept here.
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (accept_s) begin
                main_valid_d = 1'b1;
                main_data_d  = data_in;
            end else begin
                main_valid_d = 1'b0;
                main_data_d  = main_data_q;
            end
        end else if (accept_s) begin
            if (!main_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = data_in;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = data_in;
            end
        end else begin
            main_valid_d = main_valid_q;
            skid_valid_d = skid_valid_q;
        end

        ready_d = !skid_valid_d;
    end

    // Stage state registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= {DATA_W{1'b0}};
            skid_valid_q <= 1'b0;
            skid_data_q  <= {DATA_W{1'b0}};
            ready_q      <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            ready_q      <= ready_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = main_valid_q;
    assign data_out  = main_data_q;

endmodule

// File: rtl/pipeline_check.sv
// Elastic valid/ready pipeline of DEPTH skid-buffer stages.
// Define PIPELINE_CHECK_ASSERT_EN to compile in the protocol checker.
module pipeline_check
    import pipeline_check_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out
);

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("pipeline_check: DEPTH must be 1..%0d", MAX_DEPTH);
    end

    logic              valid_s [DEPTH+1];
    logic              ready_s [DEPTH+1];
    logic [DATA_W-1:0] data_s  [DEPTH+1];

    assign valid_s[0]     = in_valid;
    assign data_s[0]      = data_in;
    assign ready_s[DEPTH] = out_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        pipeline_check_stage #(.DATA_W(DATA_W)) u_stage (
            .clk      (clk),
            .rst      (rst),
            .in_valid (valid_s[k]),
            .in_ready (ready_s[k]),
            .data_in  (data_s[k]),
            .out_valid(valid_s[k+1]),
            .out_ready(ready_s[k+1]),
            .data_out (data_s[k+1])
        );
    end

    assign in_ready  = ready_s[0];
    assign out_valid = valid_s[DEPTH];
    assign data_out  = data_s[DEPTH];

`ifdef PIPELINE_CHECK_ASSERT_EN
    pipeline_check_chk #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_chk (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .data_in  (data_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .data_out (data_out)
    );
`endif

endmodule

`ifdef PIPELINE_CHECK_ASSERT_EN
// Protocol checker: output hold, reset behaviour, occupancy bound, ordering.
module pipeline_check_chk #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input logic              clk,
    input logic              rst,
    input logic              in_valid,
    input logic              in_ready,
    input logic [DATA_W-1:0] data_in,
    input logic              out_valid,
    input logic              out_ready,
    input logic [DATA_W-1:0] data_out
);

    int unsigned       cycle_q;
    logic [3:0]        occ_q;
    logic [DATA_W-1:0] sb_q [$];
    logic              acc_s;
    logic              emit_s;

    assign acc_s  = in_valid && in_ready;
    assign emit_s = out_valid && out_ready;

    // Occupancy counter and in-order scoreboard.
    always_ff @(posedge clk) begin
        cycle_q <= cycle_q + 32'd1;
        if (!rst) begin
            occ_q <= 4'd0;
            sb_q.delete();
        end else begin
            occ_q <= occ_q + {3'd0, acc_s} - {3'd0, emit_s};
            if (emit_s) begin
                if (sb_q.size() == 0) begin
                    $error("cycle %0d: word emitted with none outstanding", cycle_q);
                end else begin
                    if (sb_q[0] !== data_out) begin
                        $error("cycle %0d: order error, got %h expected %h",
                               cycle_q, data_out, sb_q[0]);
                    end
                    sb_q.pop_front();
                end
            end
            if (acc_s) begin
                sb_q.push_back(data_in);
            end
        end
    end

    a_hold: assert property (@(posedge clk) disable iff (!rst)
        out_valid && !out_ready |=> out_valid && $stable(data_out))
        else $error("cycle %0d: output dropped or changed while stalled", cycle_q);

    a_rst_ready: assert property (@(posedge clk) !rst |=> !in_ready)
        else $error("cycle %0d: in_ready high after reset edge", cycle_q);

    a_occ: assert property (@(posedge clk) disable iff (!rst)
        int'(occ_q) <= 2 * DEPTH)
        else $error("cycle %0d: occupancy %0d exceeds capacity", cycle_q, occ_q);

endmodule
`endif

// File: tb/tb_pipeline_check.sv
// Directed and random bench for pipeline_check at DEPTH=2.
module tb_pipeline_check;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_out;

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [31:0] ref_q [$];

    always #5 clk = ~clk;

    pipeline_check #(.DATA_W(32), .DEPTH(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .data_in  (data_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .data_out (data_out)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: score handshakes seen before the edge, then check hold behaviour.
    task automatic tick();
        logic        acc, emit, hold;
        logic [31:0] held;
        acc  = in_valid && in_ready && rst;
        emit = out_valid && out_ready && rst;
        hold = out_valid && !out_ready && rst;
        held = data_out;
        if (emit) begin
            if (ref_q.size() == 0) begin
                check_value("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
                check_value("order", data_out, ref_q[0]);
                void'(ref_q.pop_front());
            end
        end
        if (acc) ref_q.push_back(data_in);
        @(posedge clk);
        #1;
        if (hold) begin
            check_value("hold_valid", 32'(out_valid), 32'd1);
            check_value("hold_data", data_out, held);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          acc_cnt;
        logic [31:0] nxt;
        logic        pend;

        rst = 1'b0; in_valid = 1'b1; data_in = 32'hDEAD_BEEF; out_ready = 1'b0;
        #1;
        tick(); tick();
        check_value("rst_out_valid", 32'(out_valid), 32'd0);
        check_value("rst_data_out", data_out, 32'd0);
        check_value("rst_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0; rst = 1'b1;
        tick();
        check_value("rel_in_ready", 32'(in_ready), 32'd1);
        check_value("rel_out_valid", 32'(out_valid), 32'd0);

        // Stream: each word appears one edge after acceptance.
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            data_in  = 32'h1111_1111 * 32'(i + 1);
            tick();
            check_value("stream_in_ready", 32'(in_ready), 32'd1);
            if (i > 0) begin
                check_value("stream_valid", 32'(out_valid), 32'd1);
                check_value("stream_data", data_out, 32'h1111_1111 * 32'(i));
            end
        end
        in_valid = 1'b0;
        tick();
        check_value("stream_last", data_out, 32'h5555_5555);
        tick();
        check_value("stream_empty", 32'(out_valid), 32'd0);

        // Stall: capacity is four words at DEPTH=2.
        out_ready = 1'b0; in_valid = 1'b1; nxt = 32'hA000_0001; data_in = nxt;
        acc_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            pend = in_ready;
            tick();
            if (pend) begin
                acc_cnt++;
                nxt = nxt + 32'd1;
                data_in = nxt;
            end
        end
        check_value("stall_count", 32'(acc_cnt), 32'd4);
        check_value("stall_in_ready", 32'(in_ready), 32'd0);
        check_value("stall_valid", 32'(out_valid), 32'd1);
        check_value("stall_data", data_out, 32'hA000_0001);

        // Release: continuous output with no gap while new words keep coming.
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            pend = in_ready;
            tick();
            if (pend) begin
                nxt = nxt + 32'd1;
                data_in = nxt;
            end
            check_value("release_valid", 32'(out_valid), 32'd1);
            check_value("release_data", data_out, 32'hA000_0002 + 32'(k));
            if (k == 1) check_value("release_in_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        check_value("release_drained", 32'(ref_q.size()), 32'd0);

        // Random traffic with a protocol-correct producer.
        in_valid = 1'b0;
        for (int c = 0; c < 200; c++) begin
            pend = in_valid && !in_ready;
            tick();
            if (!pend) begin
                in_valid = 1'($urandom_range(0, 1));
                data_in  = $urandom();
            end
            out_ready = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 20; c++) tick();
        check_value("random_drained", 32'(ref_q.size()), 32'd0);
        check_value("random_idle", 32'(out_valid), 32'd0);

        // Mid-stream reset discards in-flight words.
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in = 32'hB000_0000 + 32'(i);
            tick();
        end
        in_valid = 1'b0; rst = 1'b0;
        tick();
        ref_q.delete();
        check_value("mid_rst_valid", 32'(out_valid), 32'd0);
        check_value("mid_rst_ready", 32'(in_ready), 32'd0);
        rst = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b1; data_in = 32'hCAFE_F00D;
        tick();
        in_valid = 1'b0;
        tick();
        check_value("post_rst_valid", 32'(out_valid), 32'd1);
        check_value("post_rst_data", data_out, 32'hCAFE_F00D);
        tick();
        check_value("post_rst_empty", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
